coms_multi: RTL and testbench
=============================

Name: coms_multi

Overview:
- Parametrised successor to the single-motor communications block. One byte-stream frame engine serves NUM_MOTORS motor channels addressed by ID range BASE_ID..BASE_ID+NUM_MOTORS-1, plus a broadcast ID.
- Sits between the existing uart_rx/uart_tx pair and the per-channel PID controllers.
- Adds over the previous block: per-channel register banks, broadcast setpoints, inter-byte timeout, a status snapshot taken at request time, a tx valid/ready handshake, and error counters.

Parameters:
- NUM_MOTORS, 4, number of channels (1..16).
- BASE_ID, 8'h80, ID of channel 0.
- BROADCAST_ID, 8'hFF, accepted by setpoint frames only; never answered.
- TIMEOUT_CYCLES, 50000, idle cycles between bytes that abort a frame.
- TURNAROUND_CYCLES, 16, cycles driver_enable is asserted before the first tx byte.

Ports:
- CLK  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe, rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  uart_tx accepts the byte when tx_valid&&tx_ready
- tx_data  out  8  byte to transmit
- driver_enable  out  1  RS485 driver enable
- position  in  24*NUM_MOTORS  signed per-channel encoder position, ch i at [24i+:24]
- duty  in  24*NUM_MOTORS  signed per-channel PWM duty
- current  in  16*NUM_MOTORS  signed per-channel current
- setpoint  out  24*NUM_MOTORS  signed per-channel setpoint
- control_mode  out  8*NUM_MOTORS  per-channel mode
- Kp, Ki, Kd  out  16*NUM_MOTORS each  signed gains
- crc_err_count  out  16  saturating count of CRC failures
- timeout_count  out  16  saturating count of aborted frames
- LED  out  1  pulses 1 cycle on each accepted frame

Behaviour:
- Reset (reset_n=0, async): state IDLE; every output 0 except Kp=10 per channel; shift register cleared.
- Frames (CRC-16 poly x^16+x^15+x^2+1, init 16'hFFFF, MSB-first, over the bytes after the magic, CRC sent high byte first):
  - STATUS_REQ: magic 1CE1CEBB, ID, CRC2; 7 bytes.
  - SETPOINT: magic D0D0D0D0, ID, sp[23:0] big-endian, CRC2; 10 bytes.
  - CONTROL: magic BAADA555, ID, mode, Kp2, Ki2, Kd2, sp3, CRC2; 17 bytes.
  - STATUS reply: magic 1CEB00DA, ID, mode, pos3, sp3, duty3, current2, CRC2; 19 bytes.
- States: IDLE (hunting), RECV, CHECK, SNAPSHOT, TURNAROUND, SEND.
- IDLE: each rx_valid shifts a 4-byte register. On a magic match, go to RECV with count=0, CRC=FFFF and type latched. The magic is not re-checked inside RECV.
- RECV: each rx_valid stores the byte at index count and increments count; CRC is updated incrementally on payload bytes.
  - When count reaches payload+2 go to CHECK; the frame's last byte arrives and the state changes in the same cycle.
  - Timeout counter clears on rx_valid and increments otherwise. Reaching TIMEOUT_CYCLES goes to IDLE and increments timeout_count.
- CHECK (1 cycle):
  - CRC mismatch: crc_err_count++, go to IDLE.
  - ID decode: ch=ID-BASE_ID if within range. Out of range and not broadcast: silently go to IDLE.
  - SETPOINT: update setpoint[ch], or all channels if broadcast; LED pulse; go to IDLE.
  - CONTROL: update mode, gains and setpoint of ch; a broadcast CONTROL is ignored; go to IDLE.
  - STATUS_REQ to a valid ch: go to SNAPSHOT. A broadcast STATUS_REQ is ignored.
- SNAPSHOT (1 cycle): capture ch's inputs and registers into the 19-byte out buffer in one clock; the stored CRC is computed incrementally during SEND.
- TURNAROUND: driver_enable=1, count TURNAROUND_CYCLES, then go to SEND.
- SEND: tx_valid=1 with byte idx; idx advances on tx_valid&&tx_ready.
  - Bytes 17/18 are the running CRC of bytes 4..16.
  - After the 19th handshake, tx_valid=0 and driver_enable=0 on the next cycle; go to IDLE.
- rx_valid during TURNAROUND/SEND is ignored (half-duplex).
- Counters saturate at 16'hFFFF.
- Register updates occur only in CHECK, so outputs never see partial frames.
- Reset mid-frame or mid-send: immediate return to the reset state; tx_valid drops asynchronously.

Decomposition:
- Package coms_pkg holds:
  - the magic numbers;
  - the frame lengths and payload offsets;
  - the state enum;
  - BROADCAST_ID default.
- Sub-module coms_crc16: combinational byte step, crc_out = f(data, crc_in). Instantiated twice, once for rx and once for tx.

Test Plan:
- SETPOINT for ID 8'h82 with sp=24'h012345 and correct CRC -> setpoint[2]=24'h012345 one cycle after the last byte; other channels unchanged; LED pulse.
- SETPOINT to 8'hFF with sp=24'hFFFF00 -> all NUM_MOTORS setpoints become 24'hFFFF00; no tx activity.
- CONTROL to 8'h81 with a corrupted CRC byte -> crc_err_count=1; ch1 mode and gains keep reset values (Kp=10).
- STATUS_REQ to 8'h83 with position[3]=24'h00ABCD, then position changed during SEND:
  - driver_enable high for 16 cycles before the first tx_valid;
  - 19 bytes starting 1C EB 00 DA 83 with the snapshot value 00 AB CD;
  - CRC matches the bench model;
  - tx_ready held low for 5 cycles stalls tx_data stably.
- SETPOINT with 3 bytes sent, then a gap of TIMEOUT_CYCLES -> timeout_count=1; the next valid frame is accepted.
- reset_n pulsed low at byte 10 of SEND -> tx_valid and driver_enable low immediately; all registers at reset values.

Source files
------------

// File: rtl/coms_pkg.sv
// rtl/coms_pkg.sv - frame constants, offsets and state types shared by the multi-channel frame engine
package coms_pkg;
    localparam logic [31:0] MAGIC_STATUS_REQ     = 32'h1CE1_CEBB;
    localparam logic [31:0] MAGIC_SETPOINT       = 32'hD0D0_D0D0;
    localparam logic [31:0] MAGIC_CONTROL        = 32'hBAAD_A555;
    localparam logic [31:0] MAGIC_STATUS         = 32'h1CEB_00DA;
    localparam logic [7:0]  DEFAULT_BROADCAST_ID = 8'hFF;
    localparam logic [15:0] CRC_POLY             = 16'h8005;
    localparam logic [15:0] CRC_INIT             = 16'hFFFF;

    localparam int RX_BUF_LEN    = 13;
    localparam int REPLY_HDR_LEN = 4;
    localparam int REPLY_CRC_IDX = 17;
    localparam int REPLY_LEN     = 19;

    // receive offsets count from the ID byte (first byte after the magic)
    localparam int OFS_ID          = 0;
    localparam int OFS_SP_SETPOINT = 1;
    localparam int OFS_CTRL_MODE   = 1;
    localparam int OFS_CTRL_KP     = 2;
    localparam int OFS_CTRL_KI     = 4;
    localparam int OFS_CTRL_KD     = 6;
    localparam int OFS_CTRL_SP     = 8;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RECV, ST_CHECK, ST_SNAPSHOT, ST_TURNAROUND, ST_SEND
    } state_t;

    typedef enum logic [1:0] {
        FT_STATUS_REQ, FT_SETPOINT, FT_CONTROL
    } frame_t;

    function automatic logic [3:0] payload_len(input frame_t t);
        case (t)
            FT_STATUS_REQ: return 4'd1;
            FT_SETPOINT:   return 4'd4;
            default:       return 4'd11;
        endcase
    endfunction
endpackage

// File: rtl/coms_crc16.sv
// rtl/coms_crc16.sv - one-byte combinational step of CRC-16 (0x8005), MSB first
module coms_crc16
    import coms_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [15:0] crc_in,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    always_comb begin
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ data[i])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        crc_out = c;
    end
endmodule

// File: rtl/coms_multi.sv
// rtl/coms_multi.sv - half-duplex byte-stream frame engine serving NUM_MOTORS register banks
module coms_multi
    import coms_pkg::*;
#(
    parameter int         NUM_MOTORS        = 4,
    parameter logic [7:0] BASE_ID           = 8'h80,
    parameter logic [7:0] BROADCAST_ID      = DEFAULT_BROADCAST_ID,
    parameter int         TIMEOUT_CYCLES    = 50000,
    parameter int         TURNAROUND_CYCLES = 16
) (
    input  logic                       CLK,
    input  logic                       reset_n,
    input  logic                       rx_valid,
    input  logic [7:0]                 rx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_data,
    output logic                       driver_enable,
    input  logic [24*NUM_MOTORS-1:0]   position,
    input  logic [24*NUM_MOTORS-1:0]   duty,
    input  logic [16*NUM_MOTORS-1:0]   current,
    output logic [24*NUM_MOTORS-1:0]   setpoint,
    output logic [8*NUM_MOTORS-1:0]    control_mode,
    output logic [16*NUM_MOTORS-1:0]   Kp,
    output logic [16*NUM_MOTORS-1:0]   Ki,
    output logic [16*NUM_MOTORS-1:0]   Kd,
    output logic [15:0]                crc_err_count,
    output logic [15:0]                timeout_count,
    output logic                       LED
);
    state_t      state, state_next;
    frame_t      ftype, magic_type;
    logic [23:0] shift_reg;
    logic [31:0] shift_next;
    logic        magic_hit;
    logic [3:0]  rx_cnt, plen, last_idx;
    logic [7:0]  rx_buf [RX_BUF_LEN];
    logic [15:0] rx_crc, rx_crc_next;
    logic [31:0] to_cnt;
    logic [15:0] ta_cnt;
    logic [7:0]  tx_buf [REPLY_CRC_IDX];
    logic [4:0]  tx_idx;
    logic [7:0]  tx_byte;
    logic [15:0] tx_crc, tx_crc_next;
    logic        led_r;

    logic [23:0] sp_r   [NUM_MOTORS];
    logic [7:0]  mode_r [NUM_MOTORS];
    logic [15:0] kp_r   [NUM_MOTORS];
    logic [15:0] ki_r   [NUM_MOTORS];
    logic [15:0] kd_r   [NUM_MOTORS];

    logic [8:0]  id_off;
    logic [3:0]  ch;
    logic        in_range, is_bcast, ch_hit, crc_ok, to_hit, accepted;
    logic [23:0] snap_pos, snap_sp, snap_duty;
    logic [15:0] snap_cur;
    logic [7:0]  snap_mode;

    coms_crc16 u_rx_crc (.data(rx_data), .crc_in(rx_crc), .crc_out(rx_crc_next));
    coms_crc16 u_tx_crc (.data(tx_byte), .crc_in(tx_crc), .crc_out(tx_crc_next));

    always_comb begin
        shift_next = {shift_reg, rx_data};
        magic_hit  = 1'b1;
        magic_type = FT_STATUS_REQ;
        case (shift_next)
            MAGIC_STATUS_REQ: magic_type = FT_STATUS_REQ;
            MAGIC_SETPOINT:   magic_type = FT_SETPOINT;
            MAGIC_CONTROL:    magic_type = FT_CONTROL;
            default:          magic_hit  = 1'b0;
        endcase
    end

    always_comb begin
        plen     = payload_len(ftype);
        last_idx = plen + 4'd1;
        id_off   = {1'b0, rx_buf[OFS_ID]} - {1'b0, BASE_ID};
        in_range = !id_off[8] && (id_off < 9'(NUM_MOTORS));
        ch       = id_off[3:0];
        is_bcast = (rx_buf[OFS_ID] == BROADCAST_ID);
        ch_hit   = in_range && !is_bcast;
        crc_ok   = (rx_crc == {rx_buf[plen], rx_buf[last_idx]});
        to_hit   = (to_cnt == 32'(TIMEOUT_CYCLES - 1));
        accepted = crc_ok && (ch_hit || (ftype == FT_SETPOINT && is_bcast));
    end

    always_comb begin
        snap_pos  = '0;
        snap_sp   = '0;
        snap_duty = '0;
        snap_cur  = '0;
        snap_mode = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            if (ch == i[3:0]) begin
                snap_pos  = position[24*i +: 24];
                snap_duty = duty[24*i +: 24];
                snap_cur  = current[16*i +: 16];
                snap_sp   = sp_r[i];
                snap_mode = mode_r[i];
            end
        end
    end

    always_comb begin
        if (tx_idx == 5'(REPLY_CRC_IDX))
            tx_byte = tx_crc[15:8];
        else if (tx_idx == 5'(REPLY_CRC_IDX + 1))
            tx_byte = tx_crc[7:0];
        else
            tx_byte = tx_buf[tx_idx];
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (rx_valid && magic_hit) state_next = ST_RECV;
            ST_RECV: begin
                if (rx_valid && rx_cnt == last_idx) state_next = ST_CHECK;
                else if (!rx_valid && to_hit)       state_next = ST_IDLE;
            end
            ST_CHECK:      state_next = (crc_ok && ch_hit && ftype == FT_STATUS_REQ) ? ST_SNAPSHOT : ST_IDLE;
            ST_SNAPSHOT:   state_next = ST_TURNAROUND;
            ST_TURNAROUND: if (ta_cnt == 16'(TURNAROUND_CYCLES - 1)) state_next = ST_SEND;
            ST_SEND:       if (tx_ready && tx_idx == 5'(REPLY_LEN - 1)) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            ftype         <= FT_STATUS_REQ;
            shift_reg     <= '0;
            rx_cnt        <= '0;
            rx_crc        <= '0;
            to_cnt        <= '0;
            ta_cnt        <= '0;
            tx_idx        <= '0;
            tx_crc        <= '0;
            led_r         <= 1'b0;
            crc_err_count <= '0;
            timeout_count <= '0;
            for (int i = 0; i < RX_BUF_LEN; i++)    rx_buf[i] <= '0;
            for (int i = 0; i < REPLY_CRC_IDX; i++) tx_buf[i] <= '0;
            for (int i = 0; i < NUM_MOTORS; i++) begin
                sp_r[i]   <= '0;
                mode_r[i] <= '0;
                kp_r[i]   <= 16'd10;
                ki_r[i]   <= '0;
                kd_r[i]   <= '0;
            end
        end else begin
            led_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (magic_hit) begin
                            // cleared so the tail of this magic cannot re-match on the next frame
                            shift_reg <= '0;
                            ftype     <= magic_type;
                            rx_cnt    <= '0;
                            rx_crc    <= CRC_INIT;
                            to_cnt    <= '0;
                        end else begin
                            shift_reg <= shift_next[23:0];
                        end
                    end
                end
                ST_RECV: begin
                    if (rx_valid) begin
                        rx_buf[rx_cnt] <= rx_data;
                        rx_cnt         <= rx_cnt + 4'd1;
                        to_cnt         <= '0;
                        if (rx_cnt < plen) rx_crc <= rx_crc_next;
                    end else begin
                        to_cnt <= to_cnt + 32'd1;
                        if (to_hit && timeout_count != 16'hFFFF)
                            timeout_count <= timeout_count + 16'd1;
                    end
                end
                ST_CHECK: begin
                    if (!crc_ok) begin
                        if (crc_err_count != 16'hFFFF) crc_err_count <= crc_err_count + 16'd1;
                    end else begin
                        for (int i = 0; i < NUM_MOTORS; i++) begin
                            if (ftype == FT_SETPOINT && (is_bcast || (ch_hit && ch == i[3:0])))
                                sp_r[i] <= {rx_buf[OFS_SP_SETPOINT], rx_buf[OFS_SP_SETPOINT+1],
                                            rx_buf[OFS_SP_SETPOINT+2]};
                            if (ftype == FT_CONTROL && ch_hit && ch == i[3:0]) begin
                                mode_r[i] <= rx_buf[OFS_CTRL_MODE];
                                kp_r[i]   <= {rx_buf[OFS_CTRL_KP], rx_buf[OFS_CTRL_KP+1]};
                                ki_r[i]   <= {rx_buf[OFS_CTRL_KI], rx_buf[OFS_CTRL_KI+1]};
                                kd_r[i]   <= {rx_buf[OFS_CTRL_KD], rx_buf[OFS_CTRL_KD+1]};
                                sp_r[i]   <= {rx_buf[OFS_CTRL_SP], rx_buf[OFS_CTRL_SP+1],
                                              rx_buf[OFS_CTRL_SP+2]};
                            end
                        end
                        led_r <= accepted;
                    end
                end
                ST_SNAPSHOT: begin
                    tx_buf[0]  <= MAGIC_STATUS[31:24];
                    tx_buf[1]  <= MAGIC_STATUS[23:16];
                    tx_buf[2]  <= MAGIC_STATUS[15:8];
                    tx_buf[3]  <= MAGIC_STATUS[7:0];
                    tx_buf[4]  <= rx_buf[OFS_ID];
                    tx_buf[5]  <= snap_mode;
                    tx_buf[6]  <= snap_pos[23:16];
                    tx_buf[7]  <= snap_pos[15:8];
                    tx_buf[8]  <= snap_pos[7:0];
                    tx_buf[9]  <= snap_sp[23:16];
                    tx_buf[10] <= snap_sp[15:8];
                    tx_buf[11] <= snap_sp[7:0];
                    tx_buf[12] <= snap_duty[23:16];
                    tx_buf[13] <= snap_duty[15:8];
                    tx_buf[14] <= snap_duty[7:0];
                    tx_buf[15] <= snap_cur[15:8];
                    tx_buf[16] <= snap_cur[7:0];
                    tx_crc     <= CRC_INIT;
                    tx_idx     <= '0;
                    ta_cnt     <= '0;
                end
                ST_TURNAROUND: ta_cnt <= ta_cnt + 16'd1;
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_idx <= tx_idx + 5'd1;
                        if (tx_idx >= 5'(REPLY_HDR_LEN) && tx_idx < 5'(REPLY_CRC_IDX))
                            tx_crc <= tx_crc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tx_valid      = (state == ST_SEND);
        driver_enable = (state == ST_TURNAROUND) || (state == ST_SEND);
        tx_data       = (state == ST_SEND) ? tx_byte : 8'h00;
        LED           = led_r;
        setpoint      = '0;
        control_mode  = '0;
        Kp            = '0;
        Ki            = '0;
        Kd            = '0;
        for (int i = 0; i < NUM_MOTORS; i++) begin
            setpoint[24*i +: 24]   = sp_r[i];
            control_mode[8*i +: 8] = mode_r[i];
            Kp[16*i +: 16]         = kp_r[i];
            Ki[16*i +: 16]         = ki_r[i];
            Kd[16*i +: 16]         = kd_r[i];
        end
    end
endmodule

// File: tb/tb_coms_multi.sv
// tb/tb_coms_multi.sv - scoreboard bench for coms_multi: register frames, status replies, errors, reset
module tb_coms_multi;
    localparam int NM = 4;
    localparam int TO = 200;
    localparam int TA = 16;

    logic            CLK = 1'b0;
    logic            reset_n;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            tx_valid;
    logic            tx_ready;
    logic [7:0]      tx_data;
    logic            driver_enable;
    logic [24*NM-1:0] position, duty, setpoint;
    logic [16*NM-1:0] current, Kp, Ki, Kd;
    logic [8*NM-1:0]  control_mode;
    logic [15:0]     crc_err_count, timeout_count;
    logic            LED;

    coms_multi #(
        .NUM_MOTORS(NM), .BASE_ID(8'h80), .BROADCAST_ID(8'hFF),
        .TIMEOUT_CYCLES(TO), .TURNAROUND_CYCLES(TA)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .driver_enable(driver_enable), .position(position), .duty(duty),
        .current(current), .setpoint(setpoint), .control_mode(control_mode),
        .Kp(Kp), .Ki(Ki), .Kd(Kd), .crc_err_count(crc_err_count),
        .timeout_count(timeout_count), .LED(LED)
    );

    always #5 CLK = ~CLK;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_q[$];
    logic [15:0] fcrc;
    logic [23:0] m_sp   [NM];
    logic [7:0]  m_mode [NM];
    logic [15:0] m_kp   [NM];
    logic [15:0] m_ki   [NM];
    logic [15:0] m_kd   [NM];

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) r = r[15] ? ((r << 1) ^ 16'h8005) : (r << 1);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) begin
            m_sp[i] = '0; m_mode[i] = '0; m_kp[i] = 16'd10; m_ki[i] = '0; m_kd[i] = '0;
        end
    endtask

    task automatic frame_start(input logic [31:0] magic);
        frame_q.delete();
        fcrc = 16'hFFFF;
        for (int k = 3; k >= 0; k--) frame_q.push_back(magic[8*k +: 8]);
    endtask

    task automatic frame_add(input logic [7:0] b);
        frame_q.push_back(b);
        fcrc = crc_step(fcrc, b);
    endtask

    task automatic frame_end(input logic [7:0] corrupt);
        frame_q.push_back(fcrc[15:8]);
        frame_q.push_back(fcrc[7:0] ^ corrupt);
    endtask

    task automatic build_setpoint(input logic [7:0] id, input logic [23:0] sp);
        frame_start(32'hD0D0D0D0);
        frame_add(id); frame_add(sp[23:16]); frame_add(sp[15:8]); frame_add(sp[7:0]);
        frame_end(8'h00);
    endtask

    task automatic send_frame(input int gap);
        for (int k = 0; k < frame_q.size(); k++) begin
            rx_data = frame_q[k];
            rx_valid = 1'b1;
            @(posedge CLK); #1;
            rx_valid = 1'b0;
            if (k != frame_q.size() - 1) repeat (gap) begin @(posedge CLK); #1; end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        position = {24'h00ABCD, 24'h000300, 24'h000200, 24'h000100};
        duty     = {24'h800001, 24'h000030, 24'h000020, 24'h000010};
        current  = {16'hBEEF, 16'h0003, 16'h0002, 16'h0001};
        model_reset();
        repeat (3) @(posedge CLK); #1;
        n_cmp++; if (tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
        n_cmp++; if (driver_enable !== 1'b0) begin n_err++; $display("FAIL reset_driver_enable: got %b want 0", driver_enable); end
        n_cmp++; if (setpoint !== '0) begin n_err++; $display("FAIL reset_setpoint: got %h want 0", setpoint); end
        n_cmp++; if (Kp !== {NM{16'd10}}) begin n_err++; $display("FAIL reset_kp: got %h want %h", Kp, {NM{16'd10}}); end
        n_cmp++; if ({crc_err_count, timeout_count, LED} !== '0) begin n_err++; $display("FAIL reset_counters: got %h %h %b want 0", crc_err_count, timeout_count, LED); end
        reset_n = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_setpoint_unicast();
        build_setpoint(8'h82, 24'h012345);
        send_frame(0);
        n_cmp++; if (setpoint[48 +: 24] !== 24'h0) begin n_err++; $display("FAIL sp_early: got %h want 0", setpoint[48 +: 24]); end
        m_sp[2] = 24'h012345;
        @(posedge CLK); #1;
        for (int i = 0; i < NM; i++) begin
            n_cmp++; if (setpoint[24*i +: 24] !== m_sp[i]) begin n_err++; $display("FAIL sp_unicast ch%0d: got %h want %h", i, setpoint[24*i +: 24], m_sp[i]); end
        end
        n_cmp++; if (LED !== 1'b1) begin n_err++; $display("FAIL led_pulse: got %b want 1", LED); end
        @(posedge CLK); #1;
        n_cmp++; if (LED !== 1'b0) begin n_err++; $display("FAIL led_one_cycle: got %b want 0", LED); end
    endtask

    task automatic test_setpoint_broadcast();
        logic tx_seen;
        build_setpoint(8'h84, 24'h555555);
        send_frame(0);
        @(posedge CLK); #1;
        n_cmp++; if (setpoint !== {m_sp[3], m_sp[2], m_sp[1], m_sp[0]}) begin n_err++; $display("FAIL sp_out_of_range: got %h", setpoint); end
        n_cmp++; if (LED !== 1'b0) begin n_err++; $display("FAIL led_out_of_range: got %b want 0", LED); end
        build_setpoint(8'hFF, 24'hFFFF00);
        send_frame(0);
        for (int i = 0; i < NM; i++) m_sp[i] = 24'hFFFF00;
        tx_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK); #1;
            if (tx_valid || driver_enable) tx_seen = 1'b1;
        end
        n_cmp++; if (setpoint !== {NM{24'hFFFF00}}) begin n_err++; $display("FAIL sp_broadcast: got %h want %h", setpoint, {NM{24'hFFFF00}}); end
        n_cmp++; if (tx_seen !== 1'b0) begin n_err++; $display("FAIL broadcast_no_tx: got %b want 0", tx_seen); end
    endtask

    task automatic test_control();
        frame_start(32'hBAADA555);
        frame_add(8'h81); frame_add(8'h03); frame_add(8'h01); frame_add(8'h00);
        frame_add(8'hFF); frame_add(8'hF0); frame_add(8'h00); frame_add(8'h20);
        frame_add(8'h10); frame_add(8'h00); frame_add(8'h00);
        frame_end(8'h01);
        send_frame(0);
        @(posedge CLK); #1;
        n_cmp++; if (crc_err_count !== 16'd1) begin n_err++; $display("FAIL crc_err_count: got %0d want 1", crc_err_count); end
        n_cmp++; if (control_mode[15:8] !== m_mode[1]) begin n_err++; $display("FAIL crc_err_mode: got %h want %h", control_mode[15:8], m_mode[1]); end
        n_cmp++; if (Kp[31:16] !== m_kp[1]) begin n_err++; $display("FAIL crc_err_kp: got %0d want %0d", Kp[31:16], m_kp[1]); end
        n_cmp++; if (LED !== 1'b0) begin n_err++; $display("FAIL crc_err_led: got %b want 0", LED); end
        frame_q[frame_q.size()-1] = frame_q[frame_q.size()-1] ^ 8'h01;
        send_frame(2);
        m_mode[1] = 8'h03; m_kp[1] = 16'h0100; m_ki[1] = 16'hFFF0; m_kd[1] = 16'h0020; m_sp[1] = 24'h100000;
        @(posedge CLK); #1;
        n_cmp++; if (control_mode !== {m_mode[3], m_mode[2], m_mode[1], m_mode[0]}) begin n_err++; $display("FAIL ctrl_mode: got %h", control_mode); end
        n_cmp++; if (Kp !== {m_kp[3], m_kp[2], m_kp[1], m_kp[0]}) begin n_err++; $display("FAIL ctrl_kp: got %h", Kp); end
        n_cmp++; if ({Ki[31:16], Kd[31:16]} !== {m_ki[1], m_kd[1]}) begin n_err++; $display("FAIL ctrl_ki_kd: got %h %h want %h %h", Ki[31:16], Kd[31:16], m_ki[1], m_kd[1]); end
        n_cmp++; if (setpoint[24 +: 24] !== m_sp[1]) begin n_err++; $display("FAIL ctrl_sp: got %h want %h", setpoint[24 +: 24], m_sp[1]); end
        n_cmp++; if (LED !== 1'b1) begin n_err++; $display("FAIL ctrl_led: got %b want 1", LED); end
    endtask

    task automatic test_status();
        logic [7:0]  body[$];
        logic [31:0] mg;
        logic [23:0] p, s, d;
        logic [15:0] cu, rc;
        logic [7:0]  held, e;
        int de_cycles, cyc, n;
        logic stall_ok, stalled;
        mg = 32'h1CEB00DA; p = position[72 +: 24]; s = m_sp[3]; d = duty[72 +: 24]; cu = current[48 +: 16];
        body = {mg[31:24], mg[23:16], mg[15:8], mg[7:0], 8'h83, m_mode[3],
                p[23:16], p[15:8], p[7:0], s[23:16], s[15:8], s[7:0],
                d[23:16], d[15:8], d[7:0], cu[15:8], cu[7:0]};
        rc = 16'hFFFF;
        for (int k = 4; k < 17; k++) rc = crc_step(rc, body[k]);
        foreach (body[k]) exp_q.push_back(body[k]);
        exp_q.push_back(rc[15:8]); exp_q.push_back(rc[7:0]);
        frame_start(32'h1CE1CEBB); frame_add(8'h83); frame_end(8'h00);
        send_frame(0);
        de_cycles = 0; cyc = 0;
        while (!tx_valid && cyc < 100) begin
            if (driver_enable) de_cycles++;
            @(posedge CLK); #1; cyc++;
        end
        n_cmp++; if (de_cycles !== TA) begin n_err++; $display("FAIL turnaround: got %0d want %0d", de_cycles, TA); end
        n = 0; stalled = 1'b0; stall_ok = 1'b1; cyc = 0;
        while (n < 19 && cyc < 300) begin
            if (tx_valid) begin
                if (n == 6 && !stalled) begin
                    held = tx_data;
                    repeat (5) begin
                        @(posedge CLK); #1; cyc++;
                        if (tx_data !== held || tx_valid !== 1'b1) stall_ok = 1'b0;
                    end
                    stalled = 1'b1;
                    n_cmp++; if (stall_ok !== 1'b1) begin n_err++; $display("FAIL stall_stable: got %h want %h", tx_data, held); end
                end
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                n_cmp++; if (tx_data !== e) begin n_err++; $display("FAIL reply_byte%0d: got %h want %h", n, tx_data, e); end
                tx_ready = 1'b1;
                @(posedge CLK); #1; cyc++;
                tx_ready = 1'b0;
                n++;
                if (n == 3) position[72 +: 24] = 24'h123456;
            end else begin
                @(posedge CLK); #1; cyc++;
            end
        end
        n_cmp++; if (n !== 19) begin n_err++; $display("FAIL reply_count: got %0d want 19", n); end
        n_cmp++; if ({tx_valid, driver_enable} !== 2'b00) begin n_err++; $display("FAIL reply_end: got %b want 00", {tx_valid, driver_enable}); end
        exp_q.delete();
    endtask

    task automatic test_timeout();
        frame_start(32'hD0D0D0D0);
        frame_add(8'h82); frame_add(8'h11); frame_add(8'h22);
        send_frame(0);
        repeat (TO) begin @(posedge CLK); #1; end
        n_cmp++; if (timeout_count !== 16'd1) begin n_err++; $display("FAIL timeout_count: got %0d want 1", timeout_count); end
        n_cmp++; if (setpoint[48 +: 24] !== m_sp[2]) begin n_err++; $display("FAIL timeout_sp: got %h want %h", setpoint[48 +: 24], m_sp[2]); end
        build_setpoint(8'h80, 24'h000777);
        send_frame(0);
        m_sp[0] = 24'h000777;
        @(posedge CLK); #1;
        n_cmp++; if (setpoint[0 +: 24] !== m_sp[0]) begin n_err++; $display("FAIL after_timeout_sp: got %h want %h", setpoint[0 +: 24], m_sp[0]); end
        build_setpoint(8'h81, 24'h0ABCDE);
        send_frame(TO - 1);
        m_sp[1] = 24'h0ABCDE;
        @(posedge CLK); #1;
        n_cmp++; if (setpoint[24 +: 24] !== m_sp[1]) begin n_err++; $display("FAIL slow_frame_sp: got %h want %h", setpoint[24 +: 24], m_sp[1]); end
        n_cmp++; if (timeout_count !== 16'd1) begin n_err++; $display("FAIL slow_frame_timeout: got %0d want 1", timeout_count); end
    endtask

    task automatic test_reset_mid_send();
        int cyc;
        frame_start(32'h1CE1CEBB); frame_add(8'h80); frame_end(8'h00);
        send_frame(0);
        cyc = 0;
        while (!tx_valid && cyc < 100) begin @(posedge CLK); #1; cyc++; end
        n_cmp++; if (tx_valid !== 1'b1) begin n_err++; $display("FAIL midsend_start: got %b want 1", tx_valid); end
        tx_ready = 1'b1;
        repeat (10) begin @(posedge CLK); #1; end
        reset_n = 1'b0;
        #1;
        model_reset();
        n_cmp++; if ({tx_valid, driver_enable} !== 2'b00) begin n_err++; $display("FAIL midsend_outputs: got %b want 00", {tx_valid, driver_enable}); end
        n_cmp++; if (setpoint !== '0) begin n_err++; $display("FAIL midsend_sp: got %h want 0", setpoint); end
        n_cmp++; if (Kp !== {NM{16'd10}}) begin n_err++; $display("FAIL midsend_kp: got %h want %h", Kp, {NM{16'd10}}); end
        n_cmp++; if ({control_mode, Ki, Kd} !== '0) begin n_err++; $display("FAIL midsend_regs: got %h %h %h want 0", control_mode, Ki, Kd); end
        n_cmp++; if ({crc_err_count, timeout_count} !== '0) begin n_err++; $display("FAIL midsend_counts: got %0d %0d want 0", crc_err_count, timeout_count); end
        tx_ready = 1'b0;
        @(posedge CLK); #1;
        reset_n = 1'b1;
        @(posedge CLK); #1;
    endtask

    initial begin
        test_reset();
        test_setpoint_unicast();
        test_setpoint_broadcast();
        test_control();
        test_status();
        test_timeout();
        test_reset_mid_send();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
